order_timer: RTL

- Upstream order source for the info panel.
- Spawns one order at a time and counts its remaining time down in frame-based steps.
- Drives order_out (order present) and order_time_out (5-bit countdown-bar width) to the info display stage.
- Retires the order when a bowl is served or the time runs out, and keeps served/missed tallies for the score logic.

---
 rtl/order_pkg.sv | 27 ++
 rtl/order_timer_tick_divider.sv | 28 ++
 rtl/order_timer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/order_pkg.sv
// Shared types and constants for the order timer slice.
package order_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN_WAIT,
    ACTIVE
  } order_state_t;

  localparam int ORDER_TIME_W = 5;
  localparam int COUNT_W      = 8;
  localparam int SPEEDUP_STEP = 4;
  localparam int MIN_STEPS    = 8;

  // Never drops below the floor; an order already at or under it stays put.
  function automatic logic [ORDER_TIME_W-1:0] speedup_steps(
    input logic [ORDER_TIME_W-1:0] cur
  );
    if (cur >= ORDER_TIME_W'(MIN_STEPS + SPEEDUP_STEP))
      return cur - ORDER_TIME_W'(SPEEDUP_STEP);
    else if (cur > ORDER_TIME_W'(MIN_STEPS))
      return ORDER_TIME_W'(MIN_STEPS);
    else
      return cur;
  endfunction

endpackage

// File: rtl/order_timer_tick_divider.sv
// Frame-tick prescaler: counts ticks up to term_val and pulses on the
// terminal tick; clear holds the count at zero.
module tick_divider #(
  parameter int W = 8
) (
  input  logic         pixel_clk_in,
  input  logic         rst_n_in,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] term_val,
  output logic         term_hit
);

  logic [W-1:0] cnt;

  assign term_hit = tick && !clear && (cnt == term_val);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == term_val) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/order_timer.sv
// Order spawner/countdown for the info panel.
// Optional ORDER_SPEEDUP_EN: spawn length shrinks every 4th serve.
import order_pkg::*;

module order_timer #(
  parameter int TICKS_PER_STEP = 30,
  parameter int ORDER_STEPS    = 31,
  parameter int SPAWN_DELAY    = 60
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_n_in,
  input  logic                    frame_tick_in,
  input  logic                    game_on_in,
  input  logic                    serve_in,
  output logic                    order_out,
  output logic [ORDER_TIME_W-1:0] order_time_out,
  output logic                    served_out,
  output logic                    expired_out,
  output logic [COUNT_W-1:0]      served_count_out,
  output logic [COUNT_W-1:0]      missed_count_out
);

  localparam logic [7:0] STEP_TERM  = 8'(TICKS_PER_STEP - 1);
  localparam logic [7:0] SPAWN_TERM = 8'(SPAWN_DELAY - 1);
  localparam logic [ORDER_TIME_W-1:0] INIT_STEPS =
    ORDER_TIME_W'(ORDER_STEPS);

  order_state_t state;
  logic spawn_hit, step_hit;
  logic [ORDER_TIME_W-1:0] spawn_steps;
  logic [COUNT_W-1:0] served_inc, missed_inc;

  assign served_inc = (served_count_out == '1) ?
    served_count_out : served_count_out + 1'b1;
  assign missed_inc = (missed_count_out == '1) ?
    missed_count_out : missed_count_out + 1'b1;

  tick_divider #(.W(8)) u_spawn_div (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .clear        (state != SPAWN_WAIT),
    .tick         (frame_tick_in),
    .term_val     (SPAWN_TERM),
    .term_hit     (spawn_hit)
  );

  tick_divider #(.W(8)) u_step_div (
    .pixel_clk_in (pixel_clk_in),
    .rst_n_in     (rst_n_in),
    .clear        (state != ACTIVE),
    .tick         (frame_tick_in),
    .term_val     (STEP_TERM),
    .term_hit     (step_hit)
  );

`ifdef ORDER_SPEEDUP_EN
  logic [ORDER_TIME_W-1:0] cur_steps;
  logic speedup;

  assign speedup = game_on_in && (state == ACTIVE) && serve_in &&
                   (served_count_out != '1) && (served_inc[1:0] == 2'b00);
  assign spawn_steps = cur_steps;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cur_steps <= INIT_STEPS;
    end else if (speedup) begin
      cur_steps <= speedup_steps(cur_steps);
    end
  end
`else
  assign spawn_steps = INIT_STEPS;
`endif

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      order_out        <= 1'b0;
      order_time_out   <= '0;
      served_out       <= 1'b0;
      expired_out      <= 1'b0;
      served_count_out <= '0;
      missed_count_out <= '0;
    end else begin
      served_out  <= 1'b0;
      expired_out <= 1'b0;
      if (!game_on_in) begin
        state          <= IDLE;
        order_out      <= 1'b0;
        order_time_out <= '0;
      end else begin
        unique case (state)
          IDLE: state <= SPAWN_WAIT;
          SPAWN_WAIT: begin
            if (spawn_hit) begin
              state          <= ACTIVE;
              order_out      <= 1'b1;
              order_time_out <= spawn_steps;
            end
          end
          ACTIVE: begin
            // Serve is checked first so it beats a same-cycle expiry.
            if (serve_in) begin
              state            <= SPAWN_WAIT;
              served_out       <= 1'b1;
              served_count_out <= served_inc;
              order_out        <= 1'b0;
              order_time_out   <= '0;
            end else if (step_hit) begin
              if (order_time_out != '0) begin
                order_time_out <= order_time_out - 1'b1;
              end else begin
                state            <= SPAWN_WAIT;
                expired_out      <= 1'b1;
                missed_count_out <= missed_inc;
                order_out        <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
